// File: rtl/reg_file_arbiter.sv
// Two-requester arbiter in front of a single-port register file, with per-port read data return.
// Define ARB_FIXED_PRIO_EN to give port 0 fixed priority on ties instead of round-robin.
module reg_file_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req0,
  input  logic                  Req1,
  input  logic                  Wr0,
  input  logic                  Wr1,
  input  logic [ADDR_WIDTH-1:0] Addr0,
  input  logic [ADDR_WIDTH-1:0] Addr1,
  input  logic [DATA_WIDTH-1:0] WrData0,
  input  logic [DATA_WIDTH-1:0] WrData1,
  output logic                  Gnt0,
  output logic                  Gnt1,
  output logic [DATA_WIDTH-1:0] RdData0,
  output logic [DATA_WIDTH-1:0] RdData1,
  output logic                  RdValid0,
  output logic                  RdValid1,
  output logic                  Busy,
  output logic                  RF_WrEn,
  output logic                  RF_RdEn,
  output logic [ADDR_WIDTH-1:0] RF_Address,
  output logic [DATA_WIDTH-1:0] RF_WrData,
  input  logic [DATA_WIDTH-1:0] RF_RdData
);
  typedef enum logic [1:0] {IDLE, ISSUE, RDWAIT, RDDONE} state_e;

  state_e                state_q, state_d;
  logic                  port_q, port_d;
  logic [1:0]            gnt_q, gnt_d;
  logic [1:0]            rd_valid_q, rd_valid_d;
  logic [DATA_WIDTH-1:0] rd_data0_q, rd_data0_d;
  logic [DATA_WIDTH-1:0] rd_data1_q, rd_data1_d;
  logic                  rf_wr_en_q, rf_wr_en_d;
  logic                  rf_rd_en_q, rf_rd_en_d;
  logic [ADDR_WIDTH-1:0] rf_addr_q, rf_addr_d;
  logic [DATA_WIDTH-1:0] rf_wr_data_q, rf_wr_data_d;
  logic                  win, win_wr;
`ifndef ARB_FIXED_PRIO_EN
  logic                  last_q, last_d;
`endif

  // Winner is only meaningful when at least one request is up.
  always_comb begin
`ifdef ARB_FIXED_PRIO_EN
    win = ~Req0;
`else
    win = (Req0 && Req1) ? ~last_q : Req1;
`endif
    win_wr = win ? Wr1 : Wr0;
  end

  // Outputs are computed one state ahead so that they are registered in the state they belong to.
  always_comb begin
    state_d      = state_q;
    port_d       = port_q;
    gnt_d        = '0;
    rd_valid_d   = '0;
    rd_data0_d   = rd_data0_q;
    rd_data1_d   = rd_data1_q;
    rf_wr_en_d   = 1'b0;
    rf_rd_en_d   = 1'b0;
    rf_addr_d    = rf_addr_q;
    rf_wr_data_d = rf_wr_data_q;
`ifndef ARB_FIXED_PRIO_EN
    last_d       = last_q;
`endif
    case (state_q)
      IDLE: begin
        if (Req0 || Req1) begin
          port_d       = win;
          gnt_d[win]   = 1'b1;
          rf_wr_en_d   = win_wr;
          rf_rd_en_d   = ~win_wr;
          rf_addr_d    = win ? Addr1 : Addr0;
          rf_wr_data_d = win ? WrData1 : WrData0;
`ifndef ARB_FIXED_PRIO_EN
          last_d       = win;
`endif
          state_d      = ISSUE;
        end
      end
      ISSUE:   state_d = rf_wr_en_q ? IDLE : RDWAIT;
      RDWAIT: begin
        if (port_q) rd_data1_d = RF_RdData;
        else        rd_data0_d = RF_RdData;
        rd_valid_d[port_q] = 1'b1;
        state_d = RDDONE;
      end
      RDDONE:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= IDLE;
      port_q       <= 1'b0;
      gnt_q        <= '0;
      rd_valid_q   <= '0;
      rd_data0_q   <= '0;
      rd_data1_q   <= '0;
      rf_wr_en_q   <= 1'b0;
      rf_rd_en_q   <= 1'b0;
      rf_addr_q    <= '0;
      rf_wr_data_q <= '0;
`ifndef ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
    end else begin
      state_q      <= state_d;
      port_q       <= port_d;
      gnt_q        <= gnt_d;
      rd_valid_q   <= rd_valid_d;
      rd_data0_q   <= rd_data0_d;
      rd_data1_q   <= rd_data1_d;
      rf_wr_en_q   <= rf_wr_en_d;
      rf_rd_en_q   <= rf_rd_en_d;
      rf_addr_q    <= rf_addr_d;
      rf_wr_data_q <= rf_wr_data_d;
`ifndef ARB_FIXED_PRIO_EN
      last_q       <= last_d;
`endif
    end
  end

  assign Gnt0       = gnt_q[0];
  assign Gnt1       = gnt_q[1];
  assign RdValid0   = rd_valid_q[0];
  assign RdValid1   = rd_valid_q[1];
  assign RdData0    = rd_data0_q;
  assign RdData1    = rd_data1_q;
  assign RF_WrEn    = rf_wr_en_q;
  assign RF_RdEn    = rf_rd_en_q;
  assign RF_Address = rf_addr_q;
  assign RF_WrData  = rf_wr_data_q;
  assign Busy       = (state_q != IDLE);
endmodule

// File: tb/tb_reg_file_arbiter.sv
// Scoreboard bench for reg_file_arbiter: per-port request drivers, a register file model,
// and a monitor that checks every grant and read return against queued expectations.
module tb_reg_file_arbiter;
  typedef struct { logic wr; logic [2:0] addr; logic [15:0] data; } op_t;
  typedef struct { logic port; logic wr; logic [2:0] addr; logic [15:0] data; } gexp_t;
  typedef struct { logic port; logic [15:0] data; } rexp_t;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        req0 = 1'b0, req1 = 1'b0, wr0 = 1'b0, wr1 = 1'b0;
  logic [2:0]  addr0 = '0, addr1 = '0;
  logic [15:0] wdata0 = '0, wdata1 = '0;
  logic        Gnt0, Gnt1, RdValid0, RdValid1, Busy, RF_WrEn, RF_RdEn;
  logic [15:0] RdData0, RdData1, RF_WrData;
  logic [2:0]  RF_Address;
  logic [15:0] rf_rd = '0;
  logic [15:0] mem [8];

  int errors = 0, checks = 0, cyc = 0, rf_acc = 0, gcnt0 = 0, gcnt1 = 0;
  op_t   opq0[$], opq1[$];
  gexp_t gq[$];
  rexp_t rq[$];
  int    rd_gnt_cyc[$];
  logic [15:0] sh0 = '0, sh1 = '0;

  always #5 CLK = ~CLK;

  reg_file_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .CLK(CLK), .RST(RST),
    .Req0(req0), .Req1(req1), .Wr0(wr0), .Wr1(wr1),
    .Addr0(addr0), .Addr1(addr1), .WrData0(wdata0), .WrData1(wdata1),
    .Gnt0(Gnt0), .Gnt1(Gnt1), .RdData0(RdData0), .RdData1(RdData1),
    .RdValid0(RdValid0), .RdValid1(RdValid1), .Busy(Busy),
    .RF_WrEn(RF_WrEn), .RF_RdEn(RF_RdEn), .RF_Address(RF_Address),
    .RF_WrData(RF_WrData), .RF_RdData(rf_rd)
  );

  // Register file model: read data appears one cycle after the read strobe.
  always @(posedge CLK) begin
    if (RST) mem[2] <= 16'd27;
    else begin
      if (RF_WrEn) mem[RF_Address] <= RF_WrData;
      if (RF_RdEn) rf_rd <= mem[RF_Address];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_op(input int p, input logic wr, input logic [2:0] a, input logic [15:0] d);
    op_t o;
    o.wr = wr; o.addr = a; o.data = d;
    if (p == 0) opq0.push_back(o); else opq1.push_back(o);
  endtask

  task automatic exp_gnt(input logic p, input logic wr, input logic [2:0] a, input logic [15:0] d);
    gexp_t g;
    g.port = p; g.wr = wr; g.addr = a; g.data = d;
    gq.push_back(g);
  endtask

  task automatic exp_rd(input logic p, input logic [15:0] d);
    rexp_t r;
    r.port = p; r.data = d;
    rq.push_back(r);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"},     32'({Gnt1, Gnt0}), 0);
    chk({tag, "_rdvalid"}, 32'({RdValid1, RdValid0}), 0);
    chk({tag, "_strobes"}, 32'({RF_WrEn, RF_RdEn}), 0);
    chk({tag, "_busy"},    32'(Busy), 0);
    chk({tag, "_rddata0"}, 32'(RdData0), 0);
    chk({tag, "_rddata1"}, 32'(RdData1), 0);
    chk({tag, "_addr"},    32'(RF_Address), 0);
    chk({tag, "_wrdata"},  32'(RF_WrData), 0);
  endtask

  task automatic drain(input string name);
    bit done = 1'b0;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge CLK); #1;
      done = (opq0.size() == 0) && (opq1.size() == 0) && !req0 && !req1 && !Busy &&
             (gq.size() == 0) && (rq.size() == 0);
    end
    chk(name, 32'(done), 1);
  endtask

  task automatic wait_gnt0(input int target, input string name);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK); #1;
      ok = (gcnt0 >= target);
    end
    chk(name, 32'(ok), 1);
  endtask

  // Requester drivers: hold Req until granted, then present the next queued op or drop.
  initial begin
    forever begin
      @(negedge CLK);
      if (req0 && Gnt0 && opq0.size() > 0) begin opq0.delete(0); req0 = 1'b0; end
      if (!req0 && opq0.size() > 0) begin
        wr0 = opq0[0].wr; addr0 = opq0[0].addr; wdata0 = opq0[0].data; req0 = 1'b1;
      end
      if (req1 && Gnt1 && opq1.size() > 0) begin opq1.delete(0); req1 = 1'b0; end
      if (!req1 && opq1.size() > 0) begin
        wr1 = opq1[0].wr; addr1 = opq1[0].addr; wdata1 = opq1[0].data; req1 = 1'b1;
      end
    end
  end

  // Monitor: compares DUT activity to the expectation queues.
  initial begin
    gexp_t g;
    rexp_t r;
    bit    rst_e;
    forever begin
      @(posedge CLK);
      rst_e = RST;
      cyc++;
      @(negedge CLK);
      if (rst_e) begin
        sh0 = '0; sh1 = '0;
        rd_gnt_cyc.delete();
        continue;
      end
      if (RF_WrEn || RF_RdEn) rf_acc++;
      chk("strobe_overlap", 32'(RF_WrEn & RF_RdEn), 0);
      if (Gnt0 || Gnt1) begin
        chk("one_gnt", 32'(Gnt0 & Gnt1), 0);
        chk("busy_in_issue", 32'(Busy), 1);
        if (Gnt0) gcnt0++; else gcnt1++;
        if (gq.size() == 0) chk("unexpected_gnt", 32'({Gnt1, Gnt0}), 0);
        else begin
          g = gq.pop_front();
          chk("gnt_port", 32'(Gnt1), 32'(g.port));
          chk("rf_wren", 32'(RF_WrEn), 32'(g.wr));
          chk("rf_rden", 32'(RF_RdEn), 32'(!g.wr));
          chk("rf_addr", 32'(RF_Address), 32'(g.addr));
          if (g.wr) chk("rf_wrdata", 32'(RF_WrData), 32'(g.data));
          else rd_gnt_cyc.push_back(cyc);
        end
      end else begin
        chk("strobe_without_gnt", 32'(RF_WrEn | RF_RdEn), 0);
      end
      if (RdValid0 || RdValid1) begin
        chk("one_rdvalid", 32'(RdValid0 & RdValid1), 0);
        if (rq.size() == 0) chk("unexpected_rdvalid", 32'({RdValid1, RdValid0}), 0);
        else begin
          r = rq.pop_front();
          chk("rdvalid_port", 32'(RdValid1), 32'(r.port));
          if (r.port) begin
            chk("rddata1", 32'(RdData1), 32'(r.data));
            chk("rddata0_kept", 32'(RdData0), 32'(sh0));
            sh1 = r.data;
          end else begin
            chk("rddata0", 32'(RdData0), 32'(r.data));
            chk("rddata1_kept", 32'(RdData1), 32'(sh1));
            sh0 = r.data;
          end
          // RdValid lands in the third cycle counting the grant cycle.
          if (rd_gnt_cyc.size() > 0) chk("rd_latency", 32'(cyc - rd_gnt_cyc.pop_front()), 2);
          else chk("rd_latency_missing_gnt", 0, 1);
        end
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int base, g1;
    repeat (3) @(negedge CLK);
    chk_reset("reset");
    RST = 1'b0;

    base = rf_acc;
    exp_gnt(0, 1, 3, 35);
    push_op(0, 1, 3, 35);
    drain("write_p0_drain");
    chk("write_p0_rf_acc", 32'(rf_acc - base), 1);

    base = rf_acc;
    exp_gnt(0, 0, 3, 0); exp_rd(0, 35);
    push_op(0, 0, 3, 0);
    drain("read_p0_drain");
    chk("read_p0_rf_acc", 32'(rf_acc - base), 1);

    // Port 1 raises a request during port 0's read and withdraws it before arbitration.
    base = rf_acc; g1 = gcnt1;
    exp_gnt(0, 0, 3, 0); exp_rd(0, 35);
    push_op(0, 0, 3, 0);
    wait_gnt0(gcnt0 + 1, "cancel_wait_gnt0");
    wr1 = 1'b1; addr1 = 3'd6; wdata1 = 16'd85; req1 = 1'b1;
    @(negedge CLK); #1;
    req1 = 1'b0;
    drain("cancel_drain");
    chk("cancel_no_gnt1", 32'(gcnt1 - g1), 0);
    chk("cancel_rf_acc", 32'(rf_acc - base), 1);

    // Simultaneous read on port 1 and write on port 0; port 0 was served last.
    base = rf_acc;
`ifdef ARB_FIXED_PRIO_EN
    exp_gnt(0, 1, 5, 77); exp_gnt(1, 0, 2, 0);
`else
    exp_gnt(1, 0, 2, 0); exp_gnt(0, 1, 5, 77);
`endif
    exp_rd(1, 27);
    push_op(1, 0, 2, 0);
    push_op(0, 1, 5, 77);
    drain("mixed_drain");
    chk("mixed_rf_acc", 32'(rf_acc - base), 2);

    RST = 1'b1;
    @(negedge CLK);
    chk_reset("reset2");
    RST = 1'b0;

    // Both ports held high with two writes each.
    base = rf_acc;
`ifdef ARB_FIXED_PRIO_EN
    exp_gnt(0, 1, 1, 102); exp_gnt(0, 1, 1, 104);
    exp_gnt(1, 1, 7, 143); exp_gnt(1, 1, 7, 145);
`else
    exp_gnt(0, 1, 1, 102); exp_gnt(1, 1, 7, 143);
    exp_gnt(0, 1, 1, 104); exp_gnt(1, 1, 7, 145);
`endif
    push_op(0, 1, 1, 102); push_op(0, 1, 1, 104);
    push_op(1, 1, 7, 143); push_op(1, 1, 7, 145);
    drain("tie_drain");
    chk("tie_rf_acc", 32'(rf_acc - base), 4);

    // A completed read, then a second read aborted by reset in RDWAIT.
    base = rf_acc;
    exp_gnt(0, 0, 1, 0); exp_rd(0, 104); exp_gnt(0, 0, 7, 0);
    push_op(0, 0, 1, 0); push_op(0, 0, 7, 0);
    wait_gnt0(gcnt0 + 2, "abort_wait_gnt0");
    @(posedge CLK);
    @(negedge CLK);
    chk("abort_busy_rdwait", 32'(Busy), 1);
    RST = 1'b1;
    @(posedge CLK); #1;
    chk_reset("abort");
    RST = 1'b0;
    repeat (6) @(negedge CLK);
    chk("abort_rf_acc", 32'(rf_acc - base), 2);
    drain("abort_drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/reg_file_arbiter.md
REG_FILE_ARBITER -- requirements
Module: reg_file_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 16, width of register file data words.
REQ-002 Parameter ADDR_WIDTH, default 3, width of register file address.
REQ-003 CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 RST  input  1  reset; synchronous, active-high.
REQ-005 Req0/Req1  input  1 each  access request from requester 0/1; held high until granted.
REQ-006 Wr0/Wr1  input  1 each  1 = write, 0 = read; stable while Req high.
REQ-007 Addr0/Addr1  input  ADDR_WIDTH each  target address; stable while Req high.
REQ-008 WrData0/WrData1  input  DATA_WIDTH each  write data; stable while Req high.
REQ-009 Gnt0/Gnt1  output  1 each  one-cycle grant pulse; request has been issued to register file.
REQ-010 RdData0/RdData1  output  DATA_WIDTH each  read result, held until next read for that port.
REQ-011 RdValid0/RdValid1  output  1 each  one-cycle pulse; RdDataN updated this cycle.
REQ-012 Busy  output  1  high in any state other than IDLE.
REQ-013 RF_WrEn, RF_RdEn  output  1 each  register file strobes.
REQ-014 RF_Address  output  ADDR_WIDTH; RF_WrData  output  DATA_WIDTH  register file address/data.
REQ-015 RF_RdData  input  DATA_WIDTH  register file read data, valid one cycle after RF_RdEn sampled.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, RDWAIT, RDDONE.
REQ-017 IDLE: if any Req high, arbitrate, latch winner's Wr/Addr/WrData and port id, go ISSUE; else stay.
REQ-018 ISSUE (exactly one cycle): drive RF_WrEn=Wr or RF_RdEn=~Wr, RF_Address, RF_WrData from latched values; pulse winner's Gnt; next state IDLE if write, RDWAIT if read.
REQ-019 RDWAIT: all RF strobes low; capture RF_RdData into latched port's RdData at end of cycle; go RDDONE.
REQ-020 RDDONE: pulse latched port's RdValid for one cycle; go IDLE.
REQ-021 Latency: write = 2 cycles Req-to-Gnt (IDLE, ISSUE); read RdValid 3 cycles after Gnt cycle start (ISSUE, RDWAIT, RDDONE).
REQ-022 RF_WrEn and RF_RdEn SHALL never be high simultaneously and SHALL be low outside ISSUE.
REQ-023 Round-robin: single request wins unconditionally; simultaneous requests grant the port not served last; last-served pointer updates on each grant.
REQ-024 At most one Gnt high per cycle; Gnt only for a port whose Req was high when arbitrated.
REQ-025 Req still high in cycle after Gnt SHALL be treated as a new request.
REQ-026 Req dropped before grant SHALL cancel the request with no RF access.
REQ-027 RdDataN of the non-served port SHALL remain unchanged.
REQ-028 Back-to-back writes from alternating ports: one access per 2 cycles sustained.

Reset
REQ-029 RST high at a rising edge SHALL force IDLE, all Gnt/RdValid/RF strobes/Busy low, RdData0/1 and RF_Address/RF_WrData zero, last-served pointer = port 1 (port 0 wins first tie).
REQ-030 RST mid-operation (ISSUE/RDWAIT/RDDONE) SHALL abort the access; no RdValid issued for it.

Configuration
REQ-031 Macro ARB_FIXED_PRIO_EN defined: port 0 always wins ties, pointer unused; undefined: round-robin per REQ-023.

Verification
REQ-032 Reset, Req0 write Addr0=3 WrData0=35 -> Gnt0 pulse, RF_WrEn=1 Address=3 WrData=35 in ISSUE.
REQ-033 Req0 read Addr0=3, RF model returns 35 -> RdData0=35, RdValid0 pulse 3 cycles after Gnt0.
REQ-034 Req0 and Req1 both held high (writes to 1=102, 7=143) -> grants alternate Gnt0, Gnt1; without macro order 0,1,0,1; with ARB_FIXED_PRIO_EN port 1 starved while Req0 held.
REQ-035 Read on port 1 Addr1=2 (data 27) while port 0 writes -> RdData1=27, RdData0 unchanged, no overlapping strobes.
REQ-036 RST asserted in RDWAIT -> next cycle IDLE, no RdValid, all outputs zero.
REQ-037 Req1 dropped after 1 cycle while port 0 served -> no Gnt1, no RF access for port 1.
